// File: rtl/ts_i2c_pkg.sv
// ============================================================================
// Module   : ts_i2c_pkg
// Brief    : Shared types and constants for the temperature-sensor I2C target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ts_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_PTR    = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] PTR_TEMP_MSB = 8'h00;
  localparam logic [7:0] PTR_TEMP_LSB = 8'h01;
  localparam logic [7:0] PTR_CFG      = 8'h03;
  localparam logic [7:0] PTR_ID       = 8'h0B;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h48;

  function automatic logic [7:0] next_ptr(input logic [7:0] p);
    return p + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_cond_det.sv
// ============================================================================
// Module   : i2c_bus_cond_det
// Brief    : SCL/SDA synchronizers with START, STOP and SCL edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_cond_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Preset to 1 so reset release on an idle bus never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda     = r_sda_sync[SYNC_STAGES-1];
  assign sda_s     = w_sda;
  assign scl_rise  = ~r_scl_d & w_scl;
  assign scl_fall  = r_scl_d & ~w_scl;
  assign start_det = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign stop_det  = r_scl_d & w_scl & ~r_sda_d & w_sda;

endmodule

`default_nettype wire

// File: rtl/ts_i2c_target.sv
// ============================================================================
// Module   : ts_i2c_target
// Brief    : I2C target emulating the temperature sensor (pointer/temp/cfg/ID).
//            Define TS_CFG_WRITE_EN to make cfg_reg writable at pointer 0x03.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_i2c_target
  import ts_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hCB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_value,
  output logic [7:0]  ptr_reg,
  output logic [7:0]  cfg_reg,
  output logic        busy,
  output logic        addr_hit
);

  logic       w_sda_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_rd_byte;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_tx;
  logic [15:0] r_snap;
  logic        r_rw;
`ifdef TS_CFG_WRITE_EN
  logic [7:0]  r_cfg;
  assign cfg_reg = r_cfg;
`else
  assign cfg_reg = 8'h00;
`endif

  i2c_bus_cond_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cond_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (w_sda_s),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  always_comb begin
    w_rd_byte = 8'h00;
    case (ptr_reg)
      PTR_TEMP_MSB: w_rd_byte = r_snap[15:8];
      PTR_TEMP_LSB: w_rd_byte = r_snap[7:0];
      PTR_CFG:      w_rd_byte = cfg_reg;
      PTR_ID:       w_rd_byte = ID_VALUE;
      default:      w_rd_byte = 8'h00;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  // r_bit_cnt: 0..7 data bits, 8 = byte complete / ACK slot, 9 = inside ACK clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_tx      <= 8'h00;
      r_snap    <= 16'h0000;
      r_rw      <= 1'b0;
      ptr_reg   <= 8'h00;
      sda_oe    <= 1'b0;
      addr_hit  <= 1'b0;
`ifdef TS_CFG_WRITE_EN
      r_cfg     <= 8'h00;
`endif
    end else begin
      addr_hit <= 1'b0;
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 4'd0;
        sda_oe    <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd0;
        sda_oe    <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= {r_shift[6:0], w_sda_s};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd9;
              sda_oe    <= 1'b1;
              if (r_state == ST_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  addr_hit <= 1'b1;
                  r_rw     <= r_shift[0];
                  if (r_shift[0]) r_snap <= temp_value;
                end else begin
                  sda_oe  <= 1'b0;
                  r_state <= ST_IGNORE;
                end
              end else if (r_state == ST_PTR) begin
                ptr_reg <= r_shift;
              end
`ifdef TS_CFG_WRITE_EN
              else if (ptr_reg == PTR_CFG) begin
                r_cfg <= r_shift;
              end
`endif
            end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
              r_bit_cnt <= 4'd0;
              if (r_state == ST_ADDR && r_rw) begin
                // First read bit goes out on the same falling edge that ends the ACK
                r_state <= ST_RDATA;
                sda_oe  <= ~w_rd_byte[7];
                r_tx    <= {w_rd_byte[6:0], 1'b0};
              end else begin
                sda_oe <= 1'b0;
                if (r_state == ST_ADDR)     r_state <= ST_PTR;
                else if (r_state == ST_PTR) r_state <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt < 4'd7) begin
                sda_oe    <= ~r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else if (r_bit_cnt == 4'd7) begin
                sda_oe    <= 1'b0;
                r_bit_cnt <= 4'd8;
              end else if (r_bit_cnt == 4'd9) begin
                sda_oe    <= ~w_rd_byte[7];
                r_tx      <= {w_rd_byte[6:0], 1'b0};
                r_bit_cnt <= 4'd0;
              end
            end else if (w_scl_rise && r_bit_cnt == 4'd8) begin
              if (!w_sda_s) begin
                ptr_reg   <= next_ptr(ptr_reg);
                r_bit_cnt <= 4'd9;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
